// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU,
        DONE
    } cacheState_e;

    function automatic int indexWidth(input int lines);
        return $clog2(lines);
    endfunction

    // Everything above the word offset and the index bits is tag.
    function automatic int tagWidth(input int addrW, input int lines);
        return addrW - 2 - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the cache: asynchronous read by index, one synchronous write port,
// valid bits cleared asynchronously on reset.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int DATA_W = 32,
    parameter int IDX_W  = indexWidth(16),
    parameter int TAG_W  = tagWidth(32, 16)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rdIndex,
    output logic              rdValid,
    output logic [TAG_W-1:0]  rdTag,
    output logic [DATA_W-1:0] rdData,
    input  logic              wrEn,
    input  logic [IDX_W-1:0]  wrIndex,
    input  logic [TAG_W-1:0]  wrTag,
    input  logic [DATA_W-1:0] wrData
);

    logic [LINES-1:0]  validBits;
    logic [TAG_W-1:0]  tagMem  [LINES];
    logic [DATA_W-1:0] dataMem [LINES];

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validBits <= '0;
        end else if (wrEn) begin
            validBits[wrIndex] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            tagMem[wrIndex]  <= wrTag;
            dataMem[wrIndex] <= wrData;
        end
    end

    assign rdValid = validBits[rdIndex];
    assign rdTag   = tagMem[rdIndex];
    assign rdData  = dataMem[rdIndex];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller between the memory stage
// and a variable-latency backing memory; MemReady stalls the pipeline while a miss or store is pending.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemReady,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int IDX_W = indexWidth(LINES);
    localparam int TAG_W = tagWidth(ADDR_W, LINES);

    cacheState_e       state;
    logic [DATA_W-1:0] retData;

    logic [IDX_W-1:0]  reqIndex;
    logic [TAG_W-1:0]  reqTag;
    logic [ADDR_W-1:0] wordAddr;
    logic              lineValid;
    logic [TAG_W-1:0]  lineTag;
    logic [DATA_W-1:0] lineData;
    logic              hit;

    logic              arrWe;
    logic [IDX_W-1:0]  arrIndex;
    logic [TAG_W-1:0]  arrTag;
    logic [DATA_W-1:0] arrData;

    logic              unusedAddrBits;

    assign reqIndex       = Addr[2 +: IDX_W];
    assign reqTag         = Addr[ADDR_W-1 -: TAG_W];
    assign wordAddr       = {Addr[ADDR_W-1:2], 2'b00};
    assign unusedAddrBits = ^Addr[1:0];
    assign hit            = lineValid && (lineTag == reqTag);

    dcache_line_array #(
        .LINES  (LINES),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W)
    ) u_lines (
        .clk     (clk),
        .reset   (reset),
        .rdIndex (reqIndex),
        .rdValid (lineValid),
        .rdTag   (lineTag),
        .rdData  (lineData),
        .wrEn    (arrWe),
        .wrIndex (arrIndex),
        .wrTag   (arrTag),
        .wrData  (arrData)
    );

    // A store hit updates the line on the edge leaving IDLE; a miss fill uses the captured address.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        arrWe    = 1'b0;
        arrIndex = reqIndex;
        arrTag   = reqTag;
        arrData  = WriteData;
        unique case (state)
            IDLE:    arrWe = MemWrite && hit;
            RD_MISS: begin
                arrWe    = mem_ack;
                arrIndex = mem_addr[2 +: IDX_W];
                arrTag   = mem_addr[ADDR_W-1 -: TAG_W];
                arrData  = mem_rdata;
            end
            default: ;
        endcase
    end

    // mem_addr/mem_wdata double as the capture registers for the outstanding transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            retData   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (MemWrite) begin
                        state     <= WR_THRU;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wordAddr;
                        mem_wdata <= WriteData;
                    end else if (MemRead && !hit) begin
                        state    <= RD_MISS;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= wordAddr;
                    end
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        retData <= mem_rdata;
                    end
                end
                WR_THRU: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        MemReady = 1'b0;
        unique case (state)
            IDLE:    MemReady = !MemWrite && !(MemRead && !hit);
            DONE:    MemReady = 1'b1;
            default: ;
        endcase
        if (!reset) MemReady = 1'b0;
    end

    always_comb begin
        ReadData = (state == DONE) ? retData : lineData;
        if (!reset) ReadData = '0;
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random traffic,
// checked against a line-level cache model and a word-addressed backing-memory model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] Addr, WriteData, ReadData;
    logic        MemReady;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model: 16 one-word lines plus backing store keyed by word address.
    bit          mValid [16];
    bit [25:0]   mTag   [16];
    bit [31:0]   mData  [16];
    bit [31:0]   backMem [bit [31:0]];

    dcache_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .MemReady  (MemReady),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned lineOf(input bit [31:0] a);
        return (a / 4) % 16;
    endfunction

    function automatic bit [25:0] tagOf(input bit [31:0] a);
        return a / 64;
    endfunction

    function automatic bit modelHit(input bit [31:0] a);
        return mValid[lineOf(a)] && (mTag[lineOf(a)] == tagOf(a));
    endfunction

    function automatic bit [31:0] backRead(input bit [31:0] wa);
        if (!backMem.exists(wa)) backMem[wa] = $urandom;
        return backMem[wa];
    endfunction

    // Runs one memory-stage access starting just after a rising edge; returns just after a rising edge.
    task automatic doAccess(input bit rd, input bit wr, input bit [31:0] a,
                            input bit [31:0] wd, input int lat);
        bit [31:0] wa;
        bit [31:0] rdata;
        bit        isWrite;
        wa       = a & 32'hFFFF_FFFC;
        isWrite  = wr;
        MemRead  = rd;
        MemWrite = wr;
        Addr     = a;
        WriteData = wd;
        mem_ack  = (!rd && !wr) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        if (!rd && !wr) begin
            check("idle_ready", MemReady, 1);
            check("idle_req", mem_req, 0);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            return;
        end
        if (rd && !wr && modelHit(a)) begin
            check("hit_ready", MemReady, 1);
            check("hit_data", ReadData, mData[lineOf(a)]);
            check("hit_noreq", mem_req, 0);
            @(posedge clk); #1;
            return;
        end
        check("miss_ready0", MemReady, 0);
        rdata = isWrite ? 32'h0 : backRead(wa);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            Addr      = $urandom;
            WriteData = $urandom;
            MemRead   = 1'($urandom_range(0, 1));
            MemWrite  = 1'($urandom_range(0, 1));
            if (c == lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
            check("req_high", mem_req, 1);
            check("req_we", mem_we, isWrite);
            check("req_addr", mem_addr, wa);
            if (isWrite) check("req_wdata", mem_wdata, wd);
            check("wait_ready0", MemReady, 0);
        end
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        @(negedge clk);
        check("done_ready", MemReady, 1);
        check("done_req0", mem_req, 0);
        if (!isWrite) check("done_data", ReadData, rdata);
        if (isWrite) begin
            backMem[wa] = wd;
            if (modelHit(a)) mData[lineOf(a)] = wd;
        end else begin
            mValid[lineOf(a)] = 1'b1;
            mTag[lineOf(a)]   = tagOf(a);
            mData[lineOf(a)]  = rdata;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        foreach (mValid[i]) mValid[i] = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", MemReady, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", ReadData, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Cold miss then hit.
        backMem[32'h40] = 32'hDEAD_BEEF;
        doAccess(1, 0, 32'h40, 0, 3);
        doAccess(1, 0, 32'h40, 0, 3);
        // Conflict eviction, then re-miss with an ack in the first wait cycle.
        doAccess(1, 0, 32'h80, 0, 2);
        doAccess(1, 0, 32'h40, 0, 1);
        // Write hit, write-through; later read hits new data.
        doAccess(0, 1, 32'h40, 32'h1234_5678, 2);
        doAccess(1, 0, 32'h40, 0, 1);
        // Write miss does not allocate.
        doAccess(0, 1, 32'hC0, 32'h11, 1);
        doAccess(1, 0, 32'hC0, 0, 2);
        // Simultaneous read+write behaves as a write.
        doAccess(1, 1, 32'h40, 32'hA5A5_5A5A, 2);
        doAccess(1, 0, 32'h40, 0, 1);

        // Reset in the middle of a read miss.
        MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h100;
        @(negedge clk);
        check("rm_ready0", MemReady, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rm_req", mem_req, 1);
        #1 reset = 1'b0;
        #1;
        check("rm_req_drop", mem_req, 0);
        check("rm_ready_low", MemReady, 0);
        check("rm_rdata_low", ReadData, 0);
        check("rm_addr_low", mem_addr, 0);
        @(posedge clk); #1;
        reset = 1'b1; MemRead = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check("late_ack_req", mem_req, 0);
        check("late_ack_ready", MemReady, 1);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        foreach (mValid[i]) mValid[i] = 1'b0;
        doAccess(1, 0, 32'h40, 0, 2);
        doAccess(1, 0, 32'h100, 0, 1);

        // Random traffic over 64 words (4 tags per line) to mix hits, conflicts and stores.
        for (int n = 0; n < 300; n++) begin
            int unsigned op;
            bit [31:0]   a;
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            case (op)
                0:             doAccess(0, 0, a, 0, 1);
                1, 2, 3, 4, 5: doAccess(1, 0, a, 0, $urandom_range(1, 4));
                6, 7, 8:       doAccess(0, 1, a, $urandom, $urandom_range(1, 4));
                default:       doAccess(1, 1, a, $urandom, $urandom_range(1, 4));
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
